// File: rtl/aemb_dwb_store.sv
// aemb_dwb_store: single-outstanding data-bus store unit (optional watchdog: AEMB_DWB_TIMEOUT_EN)
module aemb_dwb_store #(
    parameter int unsigned TMO = 255
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        x_stb,
    output logic        x_rdy,
    input  logic [31:0] x_adr,
    input  logic [31:0] x_dat,
    input  logic [1:0]  x_siz,
    output logic        x_done,
    output logic        x_err,
    output logic [29:0] dwb_adr_o,
    output logic [31:0] dwb_dat_o,
    output logic [3:0]  dwb_sel_o,
    output logic        dwb_stb_o,
    output logic        dwb_wre_o,
    input  logic        dwb_ack_i
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        bad;
    logic        tmo;

`ifdef AEMB_DWB_TIMEOUT_EN
    logic [7:0] wdt;
    // Watchdog expires on the last permitted BUS cycle without ack.
    assign tmo = wdt == 8'(TMO - 1);
`else
    assign tmo = 1'b0;
`endif

    assign x_rdy     = state == IDLE;
    assign dwb_wre_o = dwb_stb_o;

    // Big-endian lane steering, data replication and alignment check of the request.
    always_comb begin
        sel = 4'h0;
        dat = x_dat;
        bad = 1'b0;
        case (x_siz)
            2'b00: begin
                sel = 4'h8 >> x_adr[1:0];
                dat = {4{x_dat[7:0]}};
            end
            2'b01: begin
                sel = x_adr[1] ? 4'h3 : 4'hC;
                dat = {2{x_dat[15:0]}};
                bad = x_adr[0];
            end
            2'b10: begin
                sel = 4'hF;
                bad = |x_adr[1:0];
            end
            default: bad = 1'b1;
        endcase
    end

    // IDLE/BUS/DONE sequencer with registered bus and status outputs.
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state     <= IDLE;
            dwb_adr_o <= '0;
            dwb_dat_o <= '0;
            dwb_sel_o <= '0;
            dwb_stb_o <= 1'b0;
            x_done    <= 1'b0;
            x_err     <= 1'b0;
`ifdef AEMB_DWB_TIMEOUT_EN
            wdt       <= '0;
`endif
        end else begin
            x_done <= 1'b0;
            x_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_stb && bad) begin
                        x_err <= 1'b1;
                    end else if (x_stb) begin
                        state     <= BUS;
                        dwb_adr_o <= x_adr[31:2];
                        dwb_dat_o <= dat;
                        dwb_sel_o <= sel;
                        dwb_stb_o <= 1'b1;
`ifdef AEMB_DWB_TIMEOUT_EN
                        wdt       <= '0;
`endif
                    end
                end
                BUS: begin
                    if (dwb_ack_i) begin
                        state     <= DONE;
                        dwb_sel_o <= '0;
                        dwb_stb_o <= 1'b0;
                        x_done    <= 1'b1;
                    end else if (tmo) begin
                        state     <= IDLE;
                        dwb_sel_o <= '0;
                        dwb_stb_o <= 1'b0;
                        x_err     <= 1'b1;
                    end
`ifdef AEMB_DWB_TIMEOUT_EN
                    if (!dwb_ack_i) wdt <= wdt + 8'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aemb_dwb_store.sv
// tb_aemb_dwb_store: directed self-checking bench for aemb_dwb_store
module tb_aemb_dwb_store;
    logic        gclk = 1'b0;
    logic        grst = 1'b0;
    logic        x_stb = 1'b0;
    logic        x_rdy;
    logic [31:0] x_adr = '0;
    logic [31:0] x_dat = '0;
    logic [1:0]  x_siz = '0;
    logic        x_done;
    logic        x_err;
    logic [29:0] dwb_adr_o;
    logic [31:0] dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_stb_o;
    logic        dwb_wre_o;
    logic        dwb_ack_i = 1'b0;
    int          tests = 0;
    int          fails = 0;

    aemb_dwb_store #(.TMO(4)) dut (
        .gclk(gclk), .grst(grst), .x_stb(x_stb), .x_rdy(x_rdy),
        .x_adr(x_adr), .x_dat(x_dat), .x_siz(x_siz), .x_done(x_done),
        .x_err(x_err), .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o),
        .dwb_sel_o(dwb_sel_o), .dwb_stb_o(dwb_stb_o), .dwb_wre_o(dwb_wre_o),
        .dwb_ack_i(dwb_ack_i)
    );

    always #5 gclk = ~gclk;

    // status vector: {x_rdy, stb, wre, done, err}
    function automatic logic [4:0] st();
        return {x_rdy, dwb_stb_o, dwb_wre_o, x_done, x_err};
    endfunction

    task automatic test_reset();
        #2;
        tests++;
        if ({st(), dwb_sel_o, dwb_adr_o, dwb_dat_o} !== {5'b10000, 4'h0, 30'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset: got st=%b sel=%h adr=%h dat=%h want 10000/0/0/0", st(), dwb_sel_o, dwb_adr_o, dwb_dat_o);
        end
        @(negedge gclk);
        grst = 1'b1;
        @(negedge gclk);
    endtask

    task automatic test_byte();
        x_stb = 1'b1; x_adr = 32'h1001; x_dat = 32'h0000_00A5; x_siz = 2'b00;
        @(negedge gclk);
        x_stb = 1'b0;
        tests++;
        if ({st(), dwb_adr_o, dwb_sel_o, dwb_dat_o} !== {5'b01100, 30'h400, 4'h4, 32'hA5A5_A5A5}) begin
            fails++;
            $display("FAIL byte_bus1: got st=%b adr=%h sel=%h dat=%h want 01100/400/4/a5a5a5a5", st(), dwb_adr_o, dwb_sel_o, dwb_dat_o);
        end
        @(negedge gclk);
        tests++;
        if ({st(), dwb_adr_o, dwb_sel_o, dwb_dat_o} !== {5'b01100, 30'h400, 4'h4, 32'hA5A5_A5A5}) begin
            fails++;
            $display("FAIL byte_hold: got st=%b adr=%h sel=%h dat=%h want stable", st(), dwb_adr_o, dwb_sel_o, dwb_dat_o);
        end
        dwb_ack_i = 1'b1;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        tests++;
        if ({st(), dwb_sel_o, dwb_dat_o} !== {5'b00010, 4'h0, 32'hA5A5_A5A5}) begin
            fails++;
            $display("FAIL byte_done: got st=%b sel=%h dat=%h want 00010/0/a5a5a5a5", st(), dwb_sel_o, dwb_dat_o);
        end
        @(negedge gclk);
        tests++;
        if (st() !== 5'b10000) begin
            fails++;
            $display("FAIL byte_idle: got st=%b want 10000", st());
        end
    endtask

    task automatic test_back_to_back();
        x_stb = 1'b1; x_adr = 32'h2002; x_dat = 32'h1234_BEEF; x_siz = 2'b01;
        @(negedge gclk);
        tests++;
        if ({st(), dwb_adr_o, dwb_sel_o, dwb_dat_o} !== {5'b01100, 30'h800, 4'h3, 32'hBEEF_BEEF}) begin
            fails++;
            $display("FAIL half_bus: got st=%b adr=%h sel=%h dat=%h want 01100/800/3/beefbeef", st(), dwb_adr_o, dwb_sel_o, dwb_dat_o);
        end
        dwb_ack_i = 1'b1;
        x_adr = 32'h4000; x_dat = 32'hCAFE_F00D; x_siz = 2'b10;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        tests++;
        if (st() !== 5'b00010) begin
            fails++;
            $display("FAIL half_done: got st=%b want 00010", st());
        end
        @(negedge gclk);
        tests++;
        if (st() !== 5'b10000) begin
            fails++;
            $display("FAIL b2b_ready: got st=%b want 10000", st());
        end
        @(negedge gclk);
        x_stb = 1'b0;
        tests++;
        if ({st(), dwb_adr_o, dwb_sel_o, dwb_dat_o} !== {5'b01100, 30'h1000, 4'hF, 32'hCAFE_F00D}) begin
            fails++;
            $display("FAIL b2b_second: got st=%b adr=%h sel=%h dat=%h want 01100/1000/f/cafef00d", st(), dwb_adr_o, dwb_sel_o, dwb_dat_o);
        end
        dwb_ack_i = 1'b1;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        @(negedge gclk);
    endtask

    task automatic test_lanes();
        logic [31:0] adrs [5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20};
        logic [1:0]  sizs [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [3:0]  sels [5] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC};
        logic [31:0] dats [5] = '{32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 32'h5677_5677};
        for (int i = 0; i < 5; i++) begin
            x_stb = 1'b1; x_adr = adrs[i]; x_dat = 32'h1234_5677; x_siz = sizs[i];
            @(negedge gclk);
            x_stb = 1'b0;
            tests++;
            if ({dwb_stb_o, dwb_sel_o, dwb_dat_o} !== {1'b1, sels[i], dats[i]}) begin
                fails++;
                $display("FAIL lane%0d: got stb=%b sel=%h dat=%h want 1/%h/%h", i, dwb_stb_o, dwb_sel_o, dwb_dat_o, sels[i], dats[i]);
            end
            dwb_ack_i = 1'b1;
            @(negedge gclk);
            dwb_ack_i = 1'b0;
            @(negedge gclk);
        end
    endtask

    task automatic test_reject();
        logic [31:0] adrs [3] = '{32'h3002, 32'h3001, 32'h3000};
        logic [1:0]  sizs [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            x_stb = 1'b1; x_adr = adrs[i]; x_siz = sizs[i];
            @(negedge gclk);
            x_stb = 1'b0;
            tests++;
            if ({st(), dwb_sel_o} !== {5'b10001, 4'h0}) begin
                fails++;
                $display("FAIL reject%0d: got st=%b sel=%h want 10001/0", i, st(), dwb_sel_o);
            end
            @(negedge gclk);
            tests++;
            if (st() !== 5'b10000) begin
                fails++;
                $display("FAIL reject%0d_clear: got st=%b want 10000", i, st());
            end
        end
    endtask

    task automatic test_ack_idle();
        dwb_ack_i = 1'b1;
        @(negedge gclk);
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        tests++;
        if (st() !== 5'b10000) begin
            fails++;
            $display("FAIL ack_idle: got st=%b want 10000", st());
        end
    endtask

    task automatic test_reset_bus();
        x_stb = 1'b1; x_adr = 32'h5000; x_dat = 32'h0BAD_F00D; x_siz = 2'b10;
        @(negedge gclk);
        x_stb = 1'b0;
        grst = 1'b0;
        #1;
        tests++;
        if ({st(), dwb_sel_o, dwb_adr_o, dwb_dat_o} !== {5'b10000, 4'h0, 30'h0, 32'h0}) begin
            fails++;
            $display("FAIL rst_bus: got st=%b sel=%h adr=%h dat=%h want 10000/0/0/0", st(), dwb_sel_o, dwb_adr_o, dwb_dat_o);
        end
        @(negedge gclk);
        grst = 1'b1;
        @(negedge gclk);
        dwb_ack_i = 1'b1;
        tests++;
        if (st() !== 5'b10000) begin
            fails++;
            $display("FAIL rst_release: got st=%b want 10000", st());
        end
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        tests++;
        if (st() !== 5'b10000) begin
            fails++;
            $display("FAIL rst_late_ack: got st=%b want 10000", st());
        end
    endtask

`ifdef AEMB_DWB_TIMEOUT_EN
    task automatic test_timeout();
        x_stb = 1'b1; x_adr = 32'h6000; x_dat = 32'h1; x_siz = 2'b10;
        @(negedge gclk);
        x_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (st() !== 5'b01100) begin
                fails++;
                $display("FAIL tmo_bus%0d: got st=%b want 01100", i, st());
            end
            @(negedge gclk);
        end
        tests++;
        if ({st(), dwb_sel_o} !== {5'b10001, 4'h0}) begin
            fails++;
            $display("FAIL tmo_err: got st=%b sel=%h want 10001/0", st(), dwb_sel_o);
        end
        @(negedge gclk);
        tests++;
        if (st() !== 5'b10000) begin
            fails++;
            $display("FAIL tmo_once: got st=%b want 10000", st());
        end
        x_stb = 1'b1;
        @(negedge gclk);
        x_stb = 1'b0;
        repeat (3) @(negedge gclk);
        dwb_ack_i = 1'b1;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        tests++;
        if (st() !== 5'b00010) begin
            fails++;
            $display("FAIL tmo_ack_wins: got st=%b want 00010", st());
        end
        @(negedge gclk);
    endtask
`endif

    initial begin
        test_reset();
        test_byte();
        test_back_to_back();
        test_lanes();
        test_reject();
        test_ack_idle();
        test_reset_bus();
`ifdef AEMB_DWB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
